// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_pkg.sv
// Shared types and sizes for the four-client round-robin arbiter.
// The timeout feature is enabled by GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN.
package gf180mcu_fd_sc_mcu9t5v0__arb4_pkg;

   localparam int unsigned NReq = 4;
   localparam int unsigned PtrW = 2;
   localparam int unsigned CntW = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StGap   = 2'd2
   } arb_state_e;

   // The search for the next grant starts just above the last winner.
   function automatic logic [PtrW-1:0] ptr_after(input logic [PtrW-1:0] winner);
      return winner + 1'b1;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_pick.sv
// Combinational round-robin picker: the first set request searching upward from
// ptr_i, with wrap-around.
module gf180mcu_fd_sc_mcu9t5v0__arb4_pick
   import gf180mcu_fd_sc_mcu9t5v0__arb4_pkg::*;
(
   input  logic [NReq-1:0] req_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic            valid_o,
   output logic [PtrW-1:0] idx_o,
   output logic [NReq-1:0] onehot_o
);

   logic [PtrW-1:0] cand;

   always_comb begin
      valid_o  = |req_i;
      idx_o    = '0;
      onehot_o = '0;
      cand     = '0;
      // Walk from the farthest candidate down so the nearest one wins.
      for (int k = NReq - 1; k >= 0; k--) begin
         cand = ptr_i + PtrW'(k);
         if (req_i[cand]) begin
            idx_o = cand;
         end
      end
      if (valid_o) begin
         onehot_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_rr.sv
// Four-client round-robin arbiter with registered one-hot grant, one-cycle turnaround
// gap and registered NOR4 idle flag. Optional timeout: GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu9t5v0__arb4_rr
   import gf180mcu_fd_sc_mcu9t5v0__arb4_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 16
) (
   input  logic            CLK,
   input  logic            RN,
   input  logic [NReq-1:0] REQ,
   input  logic            EN,
   output logic [NReq-1:0] GNT,
   output logic [PtrW-1:0] GNT_ID,
   output logic            BUSY,
   output logic            ZN,
   output logic            TMO
);

   if (TMO_CYCLES < 2 || TMO_CYCLES > 255) begin : g_bad_tmo
      $error("TMO_CYCLES must lie in 2..255");
   end

   arb_state_e      state_q, state_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [NReq-1:0] gnt_q, gnt_d;
   logic [PtrW-1:0] gnt_id_q, gnt_id_d;
   logic            busy_q, busy_d;
   logic            zn_q;
   logic [NReq-1:0] req_elig;
   logic            pick_valid;
   logic [PtrW-1:0] pick_idx;
   logic [NReq-1:0] pick_onehot;

`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
   localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NReq-1:0] mask_q, mask_d;
   logic            tmo_q, tmo_d;

   assign req_elig = REQ & ~mask_q;
   assign TMO      = tmo_q;
`else
   assign req_elig = REQ;
   assign TMO      = 1'b0;
`endif

   gf180mcu_fd_sc_mcu9t5v0__arb4_pick u_pick (
      .req_i    (req_elig),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .idx_o    (pick_idx),
      .onehot_o (pick_onehot)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
      cnt_d    = cnt_q;
      // A masked client is re-admitted once its request has been seen low.
      mask_d   = mask_q & REQ;
      tmo_d    = 1'b0;
`endif
      unique case (state_q)
         StIdle, StGap: begin
            if (EN && pick_valid) begin
               state_d  = StGrant;
               gnt_d    = pick_onehot;
               gnt_id_d = pick_idx;
               busy_d   = 1'b1;
               ptr_d    = ptr_after(pick_idx);
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else begin
               state_d  = StIdle;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
            end
         end
         StGrant: begin
            if (!REQ[gnt_id_q]) begin
               state_d  = StGap;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
            end else if (cnt_q == TmoLast) begin
               state_d          = StGap;
               gnt_d            = '0;
               gnt_id_d         = '0;
               busy_d           = 1'b0;
               tmo_d            = 1'b1;
               mask_d[gnt_id_q] = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         zn_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         zn_q     <= ~|REQ;
      end
   end

`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         cnt_q  <= '0;
         mask_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
         tmo_q  <= tmo_d;
      end
   end
`endif

   assign GNT    = gnt_q;
   assign GNT_ID = gnt_id_q;
   assign BUSY   = busy_q;
   assign ZN     = zn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__arb4_rr.sv
// Bench for the round-robin arbiter: per-cycle comparison against a behavioural model
// plus directed literal checks. Timeout scenario runs when the feature macro is defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__arb4_rr;

   localparam int TMO = 4;

   logic       CLK = 1'b0;
   logic       RN;
   logic [3:0] REQ;
   logic       EN;
   logic [3:0] GNT;
   logic [1:0] GNT_ID;
   logic       BUSY;
   logic       ZN;
   logic       TMO_O;

   int n_pass   = 0;
   int n_checks = 0;
   bit done     = 1'b0;

   gf180mcu_fd_sc_mcu9t5v0__arb4_rr #(
      .TMO_CYCLES (TMO)
   ) u_dut (
      .CLK    (CLK),
      .RN     (RN),
      .REQ    (REQ),
      .EN     (EN),
      .GNT    (GNT),
      .GNT_ID (GNT_ID),
      .BUSY   (BUSY),
      .ZN     (ZN),
      .TMO    (TMO_O)
   );

   always #5 CLK = ~CLK;

   // Model: current owner (-1 = none), search pointer, mask, hold counter.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_cnt   = 0;
   logic       m_zn    = 1'b1;
   logic       m_tmo   = 1'b0;
   logic [3:0] m_mask  = '0;

   always @(posedge CLK or negedge RN) begin
      int         nxt_owner;
      int         nxt_ptr;
      int         nxt_cnt;
      logic       nxt_tmo;
      logic [3:0] nxt_mask;
      if (!RN) begin
         m_owner <= -1;
         m_ptr   <= 0;
         m_cnt   <= 0;
         m_zn    <= 1'b1;
         m_tmo   <= 1'b0;
         m_mask  <= '0;
      end else begin
         nxt_owner = m_owner;
         nxt_ptr   = m_ptr;
         nxt_cnt   = m_cnt;
         nxt_tmo   = 1'b0;
         nxt_mask  = m_mask & REQ;
         if (m_owner >= 0) begin
            if (!REQ[m_owner]) begin
               nxt_owner = -1;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
            end else if (m_cnt == TMO - 1) begin
               nxt_owner         = -1;
               nxt_tmo           = 1'b1;
               nxt_mask[m_owner] = 1'b1;
            end else begin
               nxt_cnt = m_cnt + 1;
`endif
            end
         end else if (EN) begin
            for (int k = 0; k < 4; k++) begin
               if (nxt_owner < 0 && REQ[(m_ptr + k) % 4] && !m_mask[(m_ptr + k) % 4]) begin
                  nxt_owner = (m_ptr + k) % 4;
                  nxt_ptr   = (nxt_owner + 1) % 4;
                  nxt_cnt   = 0;
               end
            end
         end
         m_owner <= nxt_owner;
         m_ptr   <= nxt_ptr;
         m_cnt   <= nxt_cnt;
         m_tmo   <= nxt_tmo;
         m_mask  <= nxt_mask;
         m_zn    <= (REQ == 4'b0000);
      end
   end

   // Per-cycle comparison of {GNT, GNT_ID, BUSY, ZN, TMO} against the model.
   always @(negedge CLK) begin
      logic [8:0] exp_v;
      logic [8:0] act_v;
      if (!done) begin
         exp_v = {(m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000,
                  (m_owner >= 0) ? 2'(m_owner) : 2'b00,
                  (m_owner >= 0), m_zn, m_tmo};
         act_v = {GNT, GNT_ID, BUSY, ZN, TMO_O};
         n_checks++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL model t=%0t: got gnt/id/busy/zn/tmo=%b want %b", $time, act_v, exp_v);
      end
   end

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      RN  = 1'b0;
      EN  = 1'b1;
      REQ = 4'($urandom);
      #23;
      check_lit("reset_gnt", 32'(GNT), 32'h0);
      check_lit("reset_busy", 32'(BUSY), 32'h0);
      check_lit("reset_zn", 32'(ZN), 32'h1);
      check_lit("reset_tmo", 32'(TMO_O), 32'h0);
      REQ = 4'b0000;
      @(posedge CLK);
      #1;
      RN = 1'b1;
      tick(1);

      // Fairness: all requesting, each owner releases after 3 cycles and re-raises.
      REQ = 4'b1111;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         check_lit("rr_grant", 32'(GNT), 32'(1 << (i % 4)));
         tick(2);
         REQ[i % 4] = 1'b0;
         tick(1);
         check_lit("rr_gap", 32'(GNT), 32'h0);
         REQ[i % 4] = 1'b1;
         tick(1);
      end
      REQ = 4'b0000;
      tick(3);

      // Single client 2.
      REQ = 4'b0100;
      tick(1);
      check_lit("single_gnt", 32'(GNT), 32'h4);
      check_lit("single_id", 32'(GNT_ID), 32'h2);
      REQ = 4'b0000;
      tick(1);
      check_lit("single_gap", 32'(GNT), 32'h0);
      check_lit("single_zn", 32'(ZN), 32'h1);
      tick(1);
      check_lit("single_idle", 32'(BUSY), 32'h0);

      // Pointer wrap: after client 3, client 0 wins over client 3.
      REQ = 4'b1000;
      tick(1);
      check_lit("wrap_first", 32'(GNT), 32'h8);
      REQ = 4'b0001;
      tick(1);
      check_lit("wrap_gap", 32'(GNT), 32'h0);
      REQ = 4'b1001;
      tick(1);
      check_lit("wrap_next", 32'(GNT), 32'h1);
      REQ = 4'b0000;
      tick(2);

      // Enable gating.
      EN  = 1'b0;
      REQ = 4'b0010;
      tick(2);
      check_lit("en_block", 32'(GNT), 32'h0);
      check_lit("en_zn", 32'(ZN), 32'h0);
      EN = 1'b1;
      tick(1);
      check_lit("en_grant", 32'(GNT), 32'h2);
      EN = 1'b0;
      tick(2);
      check_lit("en_hold", 32'(GNT), 32'h2);
      REQ = 4'b0000;
      tick(1);
      EN = 1'b1;
      tick(1);

      // Reset mid-grant clears outputs without a clock edge.
      REQ = 4'b0100;
      tick(1);
      check_lit("pre_rst_gnt", 32'(GNT), 32'h4);
      #2;
      RN = 1'b0;
      #1;
      check_lit("async_rst_gnt", 32'(GNT), 32'h0);
      check_lit("async_rst_busy", 32'(BUSY), 32'h0);
      REQ = 4'b1111;
      @(posedge CLK);
      #1;
      RN = 1'b1;
      tick(1);
      check_lit("post_rst_ptr0", 32'(GNT), 32'h1);
      REQ = 4'b0000;
      tick(3);

`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB4_TIMEOUT_EN
      // Timeout: client 1 holds past the limit, client 0 wins, client 1 stays masked.
      REQ = 4'b0010;
      tick(1);
      check_lit("tmo_hold1", 32'(GNT), 32'h2);
      REQ = 4'b0011;
      tick(3);
      check_lit("tmo_hold4", 32'(GNT), 32'h2);
      tick(1);
      check_lit("tmo_gap", 32'(GNT), 32'h0);
      check_lit("tmo_pulse", 32'(TMO_O), 32'h1);
      tick(1);
      check_lit("tmo_next", 32'(GNT), 32'h1);
      check_lit("tmo_pulse_end", 32'(TMO_O), 32'h0);
      REQ = 4'b0010;
      tick(2);
      check_lit("tmo_masked", 32'(GNT), 32'h0);
      REQ = 4'b0000;
      tick(1);
      REQ = 4'b0010;
      tick(1);
      check_lit("tmo_unmasked", 32'(GNT), 32'h2);
      REQ = 4'b0000;
      tick(3);
`else
      // Without the feature a grant is held indefinitely and TMO stays low.
      REQ = 4'b0010;
      tick(TMO + 6);
      check_lit("no_tmo_hold", 32'(GNT), 32'h2);
      check_lit("no_tmo_pulse", 32'(TMO_O), 32'h0);
      REQ = 4'b0000;
      tick(3);
`endif

      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
